// File: rtl/useq_state_ctrl.sv
// Micro-sequencer state holder for the multicycle TSC CPU.
// Holds the current control state, which feeds the microprogram ROM, and
// consumes the ROM's next-state word. It stalls in memory states until the
// access completes, enforces halt, counts retired instructions and cycles,
// and raises sticky flags for microcode and memory faults.

package useq_state_pkg;

  localparam int WORD_SIZE = 16;

  // Control-state encodings shared with the microprogram ROM.
  localparam logic [4:0] STATE_C1       = 5'd0;   // fetch (memory state)
  localparam logic [4:0] STATE_C2       = 5'd1;   // decode
  localparam logic [4:0] STATE_ADD1     = 5'd2;
  localparam logic [4:0] STATE_SUB1     = 5'd3;
  localparam logic [4:0] STATE_AND1     = 5'd4;
  localparam logic [4:0] STATE_ORR1     = 5'd5;
  localparam logic [4:0] STATE_NOT1     = 5'd6;
  localparam logic [4:0] STATE_TCP1     = 5'd7;
  localparam logic [4:0] STATE_SHL1     = 5'd8;
  localparam logic [4:0] STATE_SHR1     = 5'd9;
  localparam logic [4:0] STATE_ADI1     = 5'd10;
  localparam logic [4:0] STATE_ORI1     = 5'd11;
  localparam logic [4:0] STATE_LHI1     = 5'd12;
  localparam logic [4:0] STATE_LW1      = 5'd13;
  localparam logic [4:0] STATE_LW2      = 5'd14;  // load data access (memory state)
  localparam logic [4:0] STATE_LW3      = 5'd15;
  localparam logic [4:0] STATE_SW1      = 5'd16;
  localparam logic [4:0] STATE_SW2      = 5'd17;  // store data access (memory state)
  localparam logic [4:0] STATE_BR1      = 5'd18;
  localparam logic [4:0] STATE_JMP1     = 5'd19;
  localparam logic [4:0] STATE_JAL1     = 5'd20;
  localparam logic [4:0] STATE_JR1      = 5'd21;
  localparam logic [4:0] STATE_WRITE_RT = 5'd22;
  localparam logic [4:0] STATE_HLT1     = 5'd23;

endpackage : useq_state_pkg

module useq_state_ctrl
  import useq_state_pkg::*;
#(
  parameter int STATE_W    = 5,
  parameter int NUM_STATES = 24,
  parameter int CNT_W      = 16,
  parameter int MAX_WAIT   = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] nextstate,
  input  logic                 mem_done,
  output logic [STATE_W-1:0]   state,
  output logic                 stall,
  output logic                 inst_commit,
  output logic [CNT_W-1:0]     num_inst,
  output logic [CNT_W-1:0]     num_cycle,
  output logic                 is_halted,
  output logic                 ucode_err,
  output logic                 mem_timeout
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  localparam logic [STATE_W-1:0]   S_C1    = STATE_W'(STATE_C1);
  localparam logic [STATE_W-1:0]   S_LW2   = STATE_W'(STATE_LW2);
  localparam logic [STATE_W-1:0]   S_SW2   = STATE_W'(STATE_SW2);
  localparam logic [STATE_W-1:0]   S_HLT1  = STATE_W'(STATE_HLT1);
  localparam logic [WORD_SIZE-1:0] NS_C1   = WORD_SIZE'(STATE_C1);
  localparam logic [WORD_SIZE-1:0] NS_LIM  = WORD_SIZE'(NUM_STATES);
  // Value the wait counter holds on the stall cycle that uses up the budget.
  localparam logic [WAIT_W-1:0]    WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              is_mem_state;
  logic              is_hlt;
  logic              ns_legal;
  logic              advance;

  // Decodes of the current state and next-state word.
  assign is_mem_state = (state == S_C1) || (state == S_LW2) || (state == S_SW2);
  assign is_hlt       = (state == S_HLT1);
  // Any set bit above the state field also makes the word exceed the limit.
  assign ns_legal     = (nextstate < NS_LIM);

  assign stall   = is_mem_state && !mem_done && !is_halted;
  // Taking the ROM's next state: not halted, not HLT1, not stalled, legal word.
  assign advance = !is_halted && !is_hlt && !stall && ns_legal;

  // Retirement: leaving an instruction's last state back to fetch, or the
  // single cycle in which HLT1 is first reached.
  assign inst_commit = (advance && (state != S_C1) && (nextstate == NS_C1)) ||
                       (is_hlt && !is_halted);

  // State register, counters and sticky fault/halt flags; reset wins.
  // NOTE: every register here is written with <= so all of them update from
  // the same pre-edge values, regardless of statement order in the block.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_C1;
      wait_cnt    <= '0;
      num_inst    <= '0;
      num_cycle   <= '0;
      is_halted   <= 1'b0;
      ucode_err   <= 1'b0;
      mem_timeout <= 1'b0;
    end else if (!is_halted) begin
      num_cycle <= num_cycle + CNT_W'(1);
      if (inst_commit) begin
        num_inst <= num_inst + CNT_W'(1);
      end
      if (is_hlt) begin
        is_halted <= 1'b1;
      end else if (stall) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
        if (wait_cnt == WAIT_LAST) begin
          mem_timeout <= 1'b1;
          is_halted   <= 1'b1;
        end
      end else if (!ns_legal) begin
        ucode_err <= 1'b1;
        is_halted <= 1'b1;
      end else begin
        state    <= nextstate[STATE_W-1:0];
        wait_cnt <= '0;
      end
    end
  end

endmodule : useq_state_ctrl

// File: tb/tb_useq_state_ctrl.sv
// Directed self-checking bench for useq_state_ctrl.
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns after
// the inputs change, well clear of the next edge.

module tb_useq_state_ctrl;

  // Independent copy of the ROM state encodings used by the stimulus.
  localparam logic [4:0] S_C1       = 5'd0;
  localparam logic [4:0] S_C2       = 5'd1;
  localparam logic [4:0] S_ADI1     = 5'd10;
  localparam logic [4:0] S_LW1      = 5'd13;
  localparam logic [4:0] S_LW2      = 5'd14;
  localparam logic [4:0] S_LW3      = 5'd15;
  localparam logic [4:0] S_SW1      = 5'd16;
  localparam logic [4:0] S_SW2      = 5'd17;
  localparam logic [4:0] S_WRITE_RT = 5'd22;
  localparam logic [4:0] S_HLT1     = 5'd23;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] nextstate = 16'd0;
  logic        mem_done = 1'b1;
  logic [4:0]  state;
  logic        stall;
  logic        inst_commit;
  logic [15:0] num_inst;
  logic [15:0] num_cycle;
  logic        is_halted;
  logic        ucode_err;
  logic        mem_timeout;

  int checks = 0;
  int errors = 0;

  useq_state_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .nextstate   (nextstate),
    .mem_done    (mem_done),
    .state       (state),
    .stall       (stall),
    .inst_commit (inst_commit),
    .num_inst    (num_inst),
    .num_cycle   (num_cycle),
    .is_halted   (is_halted),
    .ucode_err   (ucode_err),
    .mem_timeout (mem_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ns_of(input logic [4:0] s);
    return {11'd0, s};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present inputs and let combinational outputs settle.
  task automatic drive(input logic [15:0] ns, input logic md);
    nextstate = ns;
    mem_done  = md;
    #1;
  endtask

  task automatic go(input logic [4:0] s);
    drive(ns_of(s), 1'b1);
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(ns_of(S_C1), 1'b1);
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (state !== S_C1) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state, S_C1); end
    checks++;
    if (num_inst !== 16'd0 || num_cycle !== 16'd0) begin
      errors++; $display("FAIL reset_counters: got inst=%0d cyc=%0d expected 0/0", num_inst, num_cycle);
    end
    checks++;
    if ({is_halted, ucode_err, mem_timeout} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b expected 000", {is_halted, ucode_err, mem_timeout});
    end
    drive(ns_of(S_C2), 1'b1);
    checks++;
    if (stall !== 1'b0 || inst_commit !== 1'b0) begin
      errors++; $display("FAIL fetch_comb: got stall=%b commit=%b expected 0/0", stall, inst_commit);
    end
    tick();
    checks++;
    if (state !== S_C2 || num_cycle !== 16'd1) begin
      errors++; $display("FAIL fetch_advance: got state=%0d cyc=%0d expected %0d/1", state, num_cycle, S_C2);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    go(S_C2);
    go(S_LW1);
    go(S_LW2);
    for (int i = 0; i < 3; i++) begin
      drive(ns_of(S_LW3), 1'b0);
      checks++;
      if (stall !== 1'b1) begin errors++; $display("FAIL wait_stall[%0d]: got %b expected 1", i, stall); end
      tick();
      checks++;
      if (state !== S_LW2) begin errors++; $display("FAIL wait_hold[%0d]: got %0d expected %0d", i, state, S_LW2); end
    end
    checks++;
    if (num_cycle !== 16'd6) begin errors++; $display("FAIL wait_cycles: got %0d expected 6", num_cycle); end
    drive(ns_of(S_LW3), 1'b1);
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL wait_release_stall: got %b expected 0", stall); end
    tick();
    checks++;
    if (state !== S_LW3) begin errors++; $display("FAIL wait_release_state: got %0d expected %0d", state, S_LW3); end
    drive(ns_of(S_C1), 1'b1);
    checks++;
    if (inst_commit !== 1'b1) begin errors++; $display("FAIL lw_commit: got %b expected 1", inst_commit); end
    tick();
    checks++;
    if (num_inst !== 16'd1 || state !== S_C1) begin
      errors++; $display("FAIL lw_retire: got inst=%0d state=%0d expected 1/%0d", num_inst, state, S_C1);
    end
  endtask

  task automatic test_retire();
    logic [4:0] seq [4];
    int commits;
    seq[0] = S_C2; seq[1] = S_ADI1; seq[2] = S_WRITE_RT; seq[3] = S_C1;
    commits = 0;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        drive(ns_of(seq[k]), 1'b1);
        if (inst_commit === 1'b1) commits++;
        tick();
      end
    end
    checks++;
    if (commits != 2) begin errors++; $display("FAIL retire_pulses: got %0d expected 2", commits); end
    checks++;
    if (num_inst !== 16'd2 || num_cycle !== 16'd8) begin
      errors++; $display("FAIL retire_counts: got inst=%0d cyc=%0d expected 2/8", num_inst, num_cycle);
    end
    checks++;
    if (state !== S_C1) begin errors++; $display("FAIL retire_state: got %0d expected %0d", state, S_C1); end
  endtask

  task automatic test_halt();
    int bad;
    do_reset();
    go(S_C2);
    go(S_HLT1);
    drive(ns_of(S_C1), 1'b1);
    checks++;
    if (inst_commit !== 1'b1 || is_halted !== 1'b0) begin
      errors++; $display("FAIL halt_commit: got commit=%b halted=%b expected 1/0", inst_commit, is_halted);
    end
    tick();
    checks++;
    if (is_halted !== 1'b1 || num_inst !== 16'd1 || num_cycle !== 16'd3) begin
      errors++; $display("FAIL halt_enter: got halted=%b inst=%0d cyc=%0d expected 1/1/3", is_halted, num_inst, num_cycle);
    end
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      drive((i % 3 == 0) ? 16'h001F : ns_of(S_C1), 1'(i % 2));
      if (inst_commit !== 1'b0 || stall !== 1'b0) bad++;
      tick();
      if (state !== S_HLT1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL halt_hold: got %0d bad cycles expected 0", bad); end
    checks++;
    if (num_inst !== 16'd1 || num_cycle !== 16'd3 || ucode_err !== 1'b0) begin
      errors++; $display("FAIL halt_frozen: got inst=%0d cyc=%0d uerr=%b expected 1/3/0", num_inst, num_cycle, ucode_err);
    end
  endtask

  task automatic test_ucode_err();
    logic [15:0] bad_ns [3];
    bad_ns[0] = 16'h001F; bad_ns[1] = 16'h0018; bad_ns[2] = 16'h0101;
    for (int i = 0; i < 3; i++) begin
      do_reset();
      go(S_C2);
      drive(bad_ns[i], 1'b1);
      tick();
      checks++;
      if (ucode_err !== 1'b1 || is_halted !== 1'b1 || state !== S_C2) begin
        errors++; $display("FAIL uerr[%0d]: got uerr=%b halted=%b state=%0d expected 1/1/%0d",
                           i, ucode_err, is_halted, state, S_C2);
      end
    end
    // Highest legal encoding is accepted.
    do_reset();
    go(S_C2);
    go(S_HLT1);
    checks++;
    if (state !== S_HLT1 || ucode_err !== 1'b0) begin
      errors++; $display("FAIL uerr_edge_legal: got state=%0d uerr=%b expected %0d/0", state, ucode_err, S_HLT1);
    end
    // Completed memory access with an illegal next state still faults.
    do_reset();
    drive(16'h0100, 1'b1);
    tick();
    checks++;
    if (ucode_err !== 1'b1 || is_halted !== 1'b1 || state !== S_C1) begin
      errors++; $display("FAIL uerr_mem_done: got uerr=%b halted=%b state=%0d expected 1/1/%0d",
                         ucode_err, is_halted, state, S_C1);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    go(S_C2);
    go(S_SW1);
    go(S_SW2);
    for (int i = 0; i < 14; i++) begin
      drive(ns_of(S_C1), 1'b0);
      tick();
    end
    checks++;
    if (mem_timeout !== 1'b0 || is_halted !== 1'b0 || num_cycle !== 16'd17) begin
      errors++; $display("FAIL timeout_early: got tmo=%b halted=%b cyc=%0d expected 0/0/17", mem_timeout, is_halted, num_cycle);
    end
    tick();
    checks++;
    if (mem_timeout !== 1'b1 || is_halted !== 1'b1 || state !== S_SW2 || num_cycle !== 16'd18) begin
      errors++; $display("FAIL timeout_hit: got tmo=%b halted=%b state=%0d cyc=%0d expected 1/1/%0d/18",
                         mem_timeout, is_halted, state, S_SW2, num_cycle);
    end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL timeout_stall: got %b expected 0", stall); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    go(S_C2);
    go(S_LW1);
    go(S_LW2);
    for (int i = 0; i < 5; i++) begin
      drive(ns_of(S_LW3), 1'b0);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (state !== S_C1 || num_cycle !== 16'd0 || {is_halted, ucode_err, mem_timeout} !== 3'b000) begin
      errors++; $display("FAIL midwait_reset: got state=%0d cyc=%0d flags=%b expected %0d/0/000",
                         state, num_cycle, {is_halted, ucode_err, mem_timeout}, S_C1);
    end
    // A cleared wait counter allows a fresh budget of stall cycles in fetch.
    for (int i = 0; i < 14; i++) begin
      drive(ns_of(S_C2), 1'b0);
      tick();
    end
    checks++;
    if (mem_timeout !== 1'b0 || state !== S_C1 || num_cycle !== 16'd14) begin
      errors++; $display("FAIL midwait_budget: got tmo=%b state=%0d cyc=%0d expected 0/%0d/14", mem_timeout, state, num_cycle, S_C1);
    end
    tick();
    checks++;
    if (mem_timeout !== 1'b1) begin errors++; $display("FAIL midwait_timeout: got %b expected 1", mem_timeout); end
  endtask

  initial begin
    test_reset();
    test_mem_wait();
    test_retire();
    test_halt();
    test_ucode_err();
    test_timeout();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_useq_state_ctrl
